// File: rtl/mprj2_enable_seq.sv
// Power sequencer for user project area 2: waits for the domain to be alive,
// then releases isolation, user reset and bus/LA enables in staged order and
// tears them down in reverse on request or on loss of power.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// OFF      | domain clamped and held in reset, waiting for request + alive
// SETTLE   | power must stay good for SETTLE_CYCLES before unclamping
// ISO_REL  | isolation released, user reset still asserted
// RST_REL  | user reset released, bus/LA paths still disabled
// ON       | domain fully up, bus/LA paths enabled
// SHUTDOWN | reset/enables dropped, isolation held open for STAGE_GAP
// FAULT    | power lost while sequencing or up; waits for clear w/o request
module mprj2_enable_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int STAGE_GAP     = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       enable_req,
    input  logic       pwr_good,
    input  logic       logic_high,
    input  logic       fault_clr,
    output logic       iso_en_n,
    output logic       user_resetb,
    output logic       la_en,
    output logic       wb_en,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_SETTLE   = 3'd1,
        S_ISO_REL  = 3'd2,
        S_RST_REL  = 3'd3,
        S_ON       = 3'd4,
        S_SHUTDOWN = 3'd5,
        S_FAULT    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(STAGE_GAP - 1);

    logic [SYNC_STAGES-1:0] pg_sync_q;
    logic [SYNC_STAGES-1:0] hi_sync_q;
    logic                   alive;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_dec;
    logic                   iso_en_n_q, user_resetb_q, la_en_q, wb_en_q;
    logic                   ready_q, fault_q;

    // Bring the asynchronous power-good and tie-high levels into clk_sys.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pg_sync_q <= '0;
            hi_sync_q <= '0;
        end else begin
            pg_sync_q <= {pg_sync_q[SYNC_STAGES-2:0], pwr_good};
            hi_sync_q <= {hi_sync_q[SYNC_STAGES-2:0], logic_high};
        end
    end

    assign alive   = pg_sync_q[SYNC_STAGES-1] & hi_sync_q[SYNC_STAGES-1];
    assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

    // Next-state and counter decode; power loss outranks every other move.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!alive && (state_q inside {S_SETTLE, S_ISO_REL, S_RST_REL, S_ON, S_SHUTDOWN})) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (enable_req && alive) begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (!enable_req) begin
                        state_d = S_OFF;
                    end else if (cnt_q == '0) begin
                        state_d = S_ISO_REL;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                S_ISO_REL: begin
                    if (!enable_req) begin
                        state_d = S_SHUTDOWN;
                        cnt_d   = GAP_LOAD;
                    end else if (cnt_q == '0) begin
                        state_d = S_RST_REL;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                S_RST_REL: begin
                    if (!enable_req) begin
                        state_d = S_SHUTDOWN;
                        cnt_d   = GAP_LOAD;
                    end else if (cnt_q == '0) begin
                        state_d = S_ON;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                S_ON: begin
                    if (!enable_req) begin
                        state_d = S_SHUTDOWN;
                        cnt_d   = GAP_LOAD;
                    end
                end
                S_SHUTDOWN: begin
                    if (cnt_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                S_FAULT: begin
                    if (fault_clr && !enable_req) begin
                        state_d = S_OFF;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    // State, counter and outputs all move on the same edge; outputs decode the new state.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q       <= S_OFF;
            cnt_q         <= '0;
            iso_en_n_q    <= 1'b0;
            user_resetb_q <= 1'b0;
            la_en_q       <= 1'b0;
            wb_en_q       <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            iso_en_n_q    <= state_d inside {S_ISO_REL, S_RST_REL, S_ON, S_SHUTDOWN};
            user_resetb_q <= state_d inside {S_RST_REL, S_ON};
            la_en_q       <= (state_d == S_ON);
            wb_en_q       <= (state_d == S_ON);
            ready_q       <= (state_d == S_ON);
            fault_q       <= (state_d == S_FAULT);
        end
    end

    assign iso_en_n    = iso_en_n_q;
    assign user_resetb = user_resetb_q;
    assign la_en       = la_en_q;
    assign wb_en       = wb_en_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mprj2_enable_seq.sv
// Scoreboard bench for mprj2_enable_seq: a driver applies directed and random
// stimulus and queues the expected outputs from a phase/elapsed-time model;
// a monitor pops and compares on every falling edge.
module tb_mprj2_enable_seq;

    localparam int SYNC_STAGES   = 2;
    localparam int SETTLE_CYCLES = 16;
    localparam int STAGE_GAP     = 4;
    localparam int CNT_W         = 8;

    localparam int P_OFF = 0, P_SETTLE = 1, P_ISO = 2, P_RST = 3, P_ON = 4, P_SHUT = 5, P_FAULT = 6;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       enable_req = 1'b0;
    logic       pwr_good = 1'b0;
    logic       logic_high = 1'b0;
    logic       fault_clr = 1'b0;
    logic       iso_en_n, user_resetb, la_en, wb_en, ready, fault;
    logic [2:0] state;

    always #5 clk = ~clk;

    mprj2_enable_seq #(
        .SYNC_STAGES  (SYNC_STAGES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .STAGE_GAP    (STAGE_GAP),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .enable_req (enable_req),
        .pwr_good   (pwr_good),
        .logic_high (logic_high),
        .fault_clr  (fault_clr),
        .iso_en_n   (iso_en_n),
        .user_resetb(user_resetb),
        .la_en      (la_en),
        .wb_en      (wb_en),
        .ready      (ready),
        .fault      (fault),
        .state      (state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       iso;
        logic       urb;
        logic       la;
        logic       wb;
        logic       rdy;
        logic       flt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;
    bit   mon_done = 0;
    int   cyc = 0;

    // Reference model: current phase, edges spent in it, and the pin history
    // still travelling through the synchronizer.
    int   ph = P_OFF;
    int   t = 0;
    bit   alive_hist[$];

    function automatic exp_t expect_of(int p);
        exp_t e;
        e.st  = 3'(p);
        e.iso = (p == P_ISO) || (p == P_RST) || (p == P_ON) || (p == P_SHUT);
        e.urb = (p == P_RST) || (p == P_ON);
        e.la  = (p == P_ON);
        e.wb  = (p == P_ON);
        e.rdy = (p == P_ON);
        e.flt = (p == P_FAULT);
        return e;
    endfunction

    task automatic model_reset();
        ph = P_OFF;
        t  = 0;
        alive_hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) alive_hist.push_back(1'b0);
    endtask

    // One clock edge of the model using the inputs the DUT just sampled.
    task automatic model_edge();
        bit alive;
        int nxt;
        if (!resetb) begin
            model_reset();
            return;
        end
        alive = alive_hist.pop_front();
        alive_hist.push_back(pwr_good & logic_high);
        nxt = ph;
        if (!alive && ph >= P_SETTLE && ph <= P_SHUT) begin
            nxt = P_FAULT;
        end else begin
            case (ph)
                P_OFF:    if (enable_req && alive) nxt = P_SETTLE;
                P_SETTLE: if (!enable_req) nxt = P_OFF;
                          else if (t == SETTLE_CYCLES - 1) nxt = P_ISO;
                P_ISO:    if (!enable_req) nxt = P_SHUT;
                          else if (t == STAGE_GAP - 1) nxt = P_RST;
                P_RST:    if (!enable_req) nxt = P_SHUT;
                          else if (t == STAGE_GAP - 1) nxt = P_ON;
                P_ON:     if (!enable_req) nxt = P_SHUT;
                P_SHUT:   if (t == STAGE_GAP - 1) nxt = P_OFF;
                P_FAULT:  if (fault_clr && !enable_req) nxt = P_OFF;
                default:  nxt = P_OFF;
            endcase
        end
        if (nxt != ph) t = 0;
        else t++;
        ph = nxt;
    endtask

    // Advance one cycle: model the edge, queue the expectation, then apply new inputs.
    task automatic step(input bit en, input bit pg, input bit hi, input bit fc, input bit rb);
        @(posedge clk);
        cyc++;
        model_edge();
        if (!rb) model_reset();
        sb_q.push_back(expect_of(ph));
        #1;
        enable_req = en;
        pwr_good   = pg;
        logic_high = hi;
        fault_clr  = fc;
        resetb     = rb;
    endtask

    task automatic hold(input int n, input bit en, input bit pg, input bit hi);
        for (int i = 0; i < n; i++) step(en, pg, hi, 1'b0, 1'b1);
    endtask

    // Monitor: compare every queued expectation against the DUT on the falling edge.
    initial begin
        exp_t e, a;
        int   idle;
        idle = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                idle = 0;
                e = sb_q.pop_front();
                a = {state, iso_en_n, user_resetb, la_en, wb_en, ready, fault};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got state=%0d iso=%b urb=%b la=%b wb=%b rdy=%b flt=%b, want state=%0d iso=%b urb=%b la=%b wb=%b rdy=%b flt=%b",
                             cyc, a.st, a.iso, a.urb, a.la, a.wb, a.rdy, a.flt,
                             e.st, e.iso, e.urb, e.la, e.wb, e.rdy, e.flt);
                end
            end else if (done) begin
                break;
            end else begin
                idle++;
                if (idle > 50) begin
                    errors++;
                    $display("FAIL monitor_timeout: got no expectation for %0d cycles, want one per cycle", idle);
                    break;
                end
            end
        end
        mon_done = 1;
    end

    // Driver: directed walk through the sequencing scenarios, then random traffic.
    initial begin
        bit r_en, r_pg, r_hi, r_fc, r_rb;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // power-up with domain already alive, then teardown
        hold(4, 1'b0, 1'b1, 1'b1);
        hold(30, 1'b1, 1'b1, 1'b1);
        hold(8, 1'b0, 1'b1, 1'b1);

        // tie-high loss while ON, clear attempts with and without request
        hold(30, 1'b1, 1'b1, 1'b1);
        hold(6, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        hold(3, 1'b1, 1'b1, 1'b1);
        hold(2, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        hold(3, 1'b0, 1'b1, 1'b1);

        // request dropped mid-SETTLE, then mid-RST_REL
        hold(12, 1'b1, 1'b1, 1'b1);
        hold(5, 1'b0, 1'b1, 1'b1);
        hold(23, 1'b1, 1'b1, 1'b1);
        hold(8, 1'b0, 1'b1, 1'b1);

        // request while power is bad, then power arrives
        hold(6, 1'b1, 1'b0, 1'b1);
        hold(8, 1'b1, 1'b1, 1'b1);

        // reset asserted in RST_REL, then full restart
        hold(13, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(30, 1'b1, 1'b1, 1'b1);

        // re-request during SHUTDOWN is ignored until OFF
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        hold(10, 1'b1, 1'b1, 1'b1);

        r_en = 1'b0; r_pg = 1'b1; r_hi = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) r_en = ~r_en;
            if (r_pg) begin
                if ($urandom_range(0, 399) == 0) r_pg = 1'b0;
            end else if ($urandom_range(0, 9) == 0) r_pg = 1'b1;
            if (r_hi) begin
                if ($urandom_range(0, 399) == 0) r_hi = 1'b0;
            end else if ($urandom_range(0, 9) == 0) r_hi = 1'b1;
            r_fc = ($urandom_range(0, 7) == 0);
            r_rb = ($urandom_range(0, 1499) != 0);
            step(r_en, r_pg, r_hi, r_fc, r_rb);
        end

        done = 1;
        for (int i = 0; i < 100 && !mon_done; i++) @(negedge clk);
        if (!mon_done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d expectations pending, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mprj2_enable_seq.md
# mprj2_enable_seq

Power-up/power-down sequencer for user project area 2 (vccd2/vssd2 domain). Watches the domain's power-good and the domain-2 tie-high output, then releases isolation, user reset and bus/LA enables in a fixed staged order, and tears them down in reverse on request or power loss. Sits in the management area between the housekeeping control register and the domain-2 isolation/enable gates; the domain-2 tie-high output feeds it as a "domain alive" qualifier.

## Interface
- SYNC_STAGES, 2, synchronizer depth for pwr_good and logic_high (≥2)
- SETTLE_CYCLES, 16, cycles power must stay good before isolation release (1..2^CNT_W)
- STAGE_GAP, 4, cycles between successive release/teardown steps (1..2^CNT_W)
- CNT_W, 8, width of the shared down-counter

- clk  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- enable_req  in  1  level, synchronous to clk; 1 = domain 2 requested on
- pwr_good  in  1  asynchronous domain-2 power-good; synchronized internally
- logic_high  in  1  HI from the domain-2 tie cell, asynchronous (0 when vccd2 is down); synchronized internally
- fault_clr  in  1  single-cycle pulse, clears FAULT
- iso_en_n  out  1  0 = domain-2 outputs clamped (isolation active)
- user_resetb  out  1  active-low reset into user area 2
- la_en  out  1  logic-analyzer path enable
- wb_en  out  1  Wishbone path enable
- ready  out  1  domain fully up (state ON)
- fault  out  1  1 in FAULT
- state  out  3  current state encoding

## Operation
- alive = pg_s & hi_s (both synchronized values).
- States/encoding: OFF=0, SETTLE=1, ISO_REL=2, RST_REL=3, ON=4, SHUTDOWN=5, FAULT=6; 7 unused, recovers to OFF next edge.
- Outputs are registered, updated on the same edge as the state; values per state (iso_en_n, user_resetb, la_en/wb_en): OFF 0,0,0; SETTLE 0,0,0; ISO_REL 1,0,0; RST_REL 1,1,0; ON 1,1,1; SHUTDOWN 1,0,0; FAULT 0,0,0. ready=1 only in ON; fault=1 only in FAULT.
- OFF: enable_req & alive → SETTLE, cnt ← SETTLE_CYCLES−1.
- SETTLE: !alive → FAULT; else !enable_req → OFF; else cnt==0 → ISO_REL, cnt ← STAGE_GAP−1; else cnt−1.
- ISO_REL: cnt==0 → RST_REL, cnt ← STAGE_GAP−1.
- RST_REL: cnt==0 → ON.
- ON: !enable_req → SHUTDOWN, cnt ← STAGE_GAP−1.
- SHUTDOWN: cnt==0 → OFF.
- enable_req dropping in ISO_REL/RST_REL → SHUTDOWN, cnt ← STAGE_GAP−1.
- !alive in any state except OFF/FAULT → FAULT (priority over all other transitions).
- FAULT: fault_clr & !enable_req → OFF; fault_clr with enable_req=1 is ignored.
- enable_req re-asserted during SHUTDOWN: ignored until OFF is reached.
- Counter saturates at 0; never wraps.

## Timing
- Reset (async assert, deassertion synchronous to clk): state=OFF, cnt=0, synchronizers=0, all outputs 0.
- pwr_good/logic_high reach alive after SYNC_STAGES edges.
- With alive already 1 and enable_req rising before edge 0: SETTLE at edge 1, iso_en_n=1 at edge 1+SETTLE_CYCLES, user_resetb=1 at +STAGE_GAP, la_en/wb_en/ready=1 at +2·STAGE_GAP (defaults: edges 17, 21, 25).
- Teardown from ON: la_en/wb_en/ready/user_resetb=0 on the edge after enable_req drops; iso_en_n=0 STAGE_GAP edges later.
- Power loss: outputs 0 on the edge after alive falls (SYNC_STAGES+1 edges after the pin).
- Reset mid-sequence: all outputs 0 immediately (async); resumes from OFF.

## Test plan
- Power-up, defaults, pg/hi high, enable_req 0→1 at edge 0 → iso_en_n↑ edge 17, user_resetb↑ 21, la_en/wb_en/ready↑ 25, state 1→2→3→4.
- Power-down from ON: enable_req→0 → state 5; user_resetb/la_en/wb_en 0 next edge; iso_en_n 0 and state 0 four edges later.
- logic_high drops in ON → fault=1, all outputs 0 at sync+1 edges; fault_clr with enable_req=1 held → stays FAULT; drop enable_req, pulse fault_clr → OFF.
- enable_req dropped in SETTLE at count 5 → OFF next edge, iso_en_n never rises; dropped in RST_REL → SHUTDOWN, iso_en_n clamps after 4 edges.
- enable_req=1 while pwr_good=0 → stays OFF; pwr_good rises → SETTLE 3 edges later (2-stage sync + 1).
- resetb asserted in RST_REL → all outputs 0 asynchronously, state 0; after release, sequence restarts from OFF.
